// File: rtl/uart_rx_frame_check_pkg.sv
// Shared definitions for the UART receive frame checker:
// parity polarity constants, RX FSM state encoding, default width.
package uart_rx_frame_check_pkg;

    localparam int DEF_DATA_WIDTH = 8;

    localparam logic EVEN_PARITY = 1'b0;
    localparam logic ODD_PARITY  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_rx_frame_check_parity.sv
// Expected-parity generation and compare for a received word,
// using the same even/odd convention as the TX parity generator.
module rx_parity_check
    import uart_rx_frame_check_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  par_typ_i,
    input  logic                  par_bit_i,
    output logic                  par_fail_o
);

    logic exp_par;

    assign exp_par    = (par_typ_i == ODD_PARITY) ? ~^data_i : ^data_i;
    assign par_fail_o = (par_bit_i != exp_par);

endmodule

// File: rtl/uart_rx_frame_check.sv
// UART RX deserializer: LSB-first shift-in with start, parity and
// stop checking; one-cycle data/error strobes after the stop bit.
module uart_rx_frame_check
    import uart_rx_frame_check_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  bit_valid,
    input  logic                  sampled_bit,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH);

    rx_state_e             state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_d;
    logic [CW-1:0]         cnt_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_fail_q;
    logic                  par_fail;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  data_valid_q;
    logic                  par_err_q;
    logic                  stp_err_q;
    logic                  busy_q;
    logic                  last_bit;

    assign shift_d  = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
    assign last_bit = (cnt_q == CW'(DATA_WIDTH - 1));

    rx_parity_check #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_par (
        .data_i     (shift_q),
        .par_typ_i  (par_typ_q),
        .par_bit_i  (sampled_bit),
        .par_fail_o (par_fail)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= EVEN_PARITY;
            par_fail_q   <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            if (bit_valid) begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (!sampled_bit) begin
                            state_q    <= ST_DATA;
                            par_en_q   <= PAR_EN;
                            par_typ_q  <= PAR_TYP;
                            cnt_q      <= '0;
                            par_fail_q <= 1'b0;
                            busy_q     <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        shift_q <= shift_d;
                        if (last_bit) begin
                            state_q <= par_en_q ? ST_PARITY : ST_STOP;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_PARITY: begin
                        par_fail_q <= par_fail;
                        state_q    <= ST_STOP;
                    end
                    ST_STOP: begin
                        // A low stop bit ends the frame; it never doubles as a start bit.
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        par_err_q <= par_fail_q;
                        stp_err_q <= ~sampled_bit;
                        if (!par_fail_q && sampled_bit) begin
                            p_data_q     <= shift_q;
                            data_valid_q <= 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign P_DATA     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Directed bench for uart_rx_frame_check with hand-computed frames.
module tb_uart_rx_frame_check;

    logic       CLK;
    logic       RST;
    logic       bit_valid;
    logic       sampled_bit;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       busy;

    int nvec;
    int nerr;
    int npulse;

    uart_rx_frame_check #(.DATA_WIDTH(8)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .bit_valid   (bit_valid),
        .sampled_bit (sampled_bit),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .P_DATA      (P_DATA),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .busy        (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (data_valid || par_err || stp_err) npulse++;
    end

    task automatic send_bit(input logic b);
        @(posedge CLK); #1;
        bit_valid   = 1'b1;
        sampled_bit = b;
        @(posedge CLK); #1;
        bit_valid   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic hp,
                              input logic p, input logic stp);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (hp) send_bit(p);
        send_bit(stp);
    endtask

    task automatic test_reset;
        RST = 1'b0; bit_valid = 1'b0; sampled_bit = 1'b1;
        PAR_EN = 1'b0; PAR_TYP = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        nvec++; if (P_DATA !== 8'h00) begin nerr++; $display("FAIL rst_pdata: got %h want 00", P_DATA); end
        nvec++; if ({data_valid, par_err, stp_err, busy} !== 4'b0000) begin nerr++; $display("FAIL rst_flags: got %b want 0000", {data_valid, par_err, stp_err, busy}); end
        RST = 1'b1;
        // line low without a strobe must not start a frame
        sampled_bit = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL nostrobe_busy: got %b want 0", busy); end
        sampled_bit = 1'b1;
    endtask

    task automatic test_even_ok;
        PAR_EN = 1'b1; PAR_TYP = 1'b0;
        send_bit(1'b0);
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL a5_busy: got %b want 1", busy); end
        for (int i = 0; i < 8; i++) send_bit(1'(8'hA5 >> i));
        send_bit(1'b0);
        send_bit(1'b1);
        nvec++; if (data_valid !== 1'b1) begin nerr++; $display("FAIL a5_dv: got %b want 1", data_valid); end
        nvec++; if (P_DATA !== 8'hA5) begin nerr++; $display("FAIL a5_pdata: got %h want a5", P_DATA); end
        nvec++; if ({par_err, stp_err, busy} !== 3'b000) begin nerr++; $display("FAIL a5_errs: got %b want 000", {par_err, stp_err, busy}); end
        @(posedge CLK); #1;
        nvec++; if (data_valid !== 1'b0) begin nerr++; $display("FAIL a5_dv_pulse: got %b want 0", data_valid); end
    endtask

    task automatic test_odd_err;
        PAR_EN = 1'b1; PAR_TYP = 1'b1;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        nvec++; if (par_err !== 1'b1) begin nerr++; $display("FAIL 3c_perr: got %b want 1", par_err); end
        nvec++; if ({data_valid, stp_err} !== 2'b00) begin nerr++; $display("FAIL 3c_dv_se: got %b want 00", {data_valid, stp_err}); end
        nvec++; if (P_DATA !== 8'hA5) begin nerr++; $display("FAIL 3c_pdata: got %h want a5", P_DATA); end
        @(posedge CLK); #1;
        nvec++; if (par_err !== 1'b0) begin nerr++; $display("FAIL 3c_perr_pulse: got %b want 0", par_err); end
    endtask

    task automatic test_stop_err;
        PAR_EN = 1'b0; PAR_TYP = 1'b0;
        send_frame(8'h81, 1'b0, 1'b0, 1'b0);
        nvec++; if (stp_err !== 1'b1) begin nerr++; $display("FAIL 81_serr: got %b want 1", stp_err); end
        nvec++; if ({data_valid, par_err} !== 2'b00) begin nerr++; $display("FAIL 81_dv_pe: got %b want 00", {data_valid, par_err}); end
        nvec++; if (P_DATA !== 8'hA5) begin nerr++; $display("FAIL 81_pdata: got %h want a5", P_DATA); end
        repeat (3) send_bit(1'b1);
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL 81_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        PAR_EN = 1'b1; PAR_TYP = 1'b0;
        send_frame(8'h00, 1'b1, 1'b0, 1'b1);
        nvec++; if ({data_valid, P_DATA} !== {1'b1, 8'h00}) begin nerr++; $display("FAIL b2b0: got %b/%h want 1/00", data_valid, P_DATA); end
        send_frame(8'hFF, 1'b1, 1'b0, 1'b1);
        nvec++; if ({data_valid, P_DATA} !== {1'b1, 8'hFF}) begin nerr++; $display("FAIL b2b1: got %b/%h want 1/ff", data_valid, P_DATA); end
        nvec++; if ({par_err, stp_err} !== 2'b00) begin nerr++; $display("FAIL b2b_errs: got %b want 00", {par_err, stp_err}); end
    endtask

    task automatic test_reset_mid;
        int p0;
        PAR_EN = 1'b1; PAR_TYP = 1'b0;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'h5A >> i));
        p0 = npulse;
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        nvec++; if ({busy, P_DATA} !== 9'h000) begin nerr++; $display("FAIL midrst_state: got %b/%h want 0/00", busy, P_DATA); end
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        nvec++; if (npulse !== p0) begin nerr++; $display("FAIL midrst_pulse: got %0d want %0d", npulse, p0); end
        send_frame(8'h12, 1'b1, 1'b0, 1'b1);
        nvec++; if ({data_valid, P_DATA} !== {1'b1, 8'h12}) begin nerr++; $display("FAIL 12_rx: got %b/%h want 1/12", data_valid, P_DATA); end
        nvec++; if ({par_err, stp_err} !== 2'b00) begin nerr++; $display("FAIL 12_errs: got %b want 00", {par_err, stp_err}); end
    endtask

    task automatic test_latch;
        PAR_EN = 1'b1; PAR_TYP = 1'b0;
        send_bit(1'b0);
        PAR_TYP = 1'b1;
        PAR_EN  = 1'b0;
        for (int i = 0; i < 8; i++) send_bit(1'(8'h07 >> i));
        send_bit(1'b1);
        send_bit(1'b1);
        nvec++; if ({data_valid, P_DATA} !== {1'b1, 8'h07}) begin nerr++; $display("FAIL 07_latch: got %b/%h want 1/07", data_valid, P_DATA); end
        nvec++; if ({par_err, stp_err} !== 2'b00) begin nerr++; $display("FAIL 07_errs: got %b want 00", {par_err, stp_err}); end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        npulse = 0;
        test_reset;
        test_even_ok;
        test_odd_err;
        test_stop_err;
        test_back_to_back;
        test_reset_mid;
        test_latch;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
